regfile_write_arbiter: RTL and testbench

- Shares the single write port (wr/ad/rd) of the 4x8-bit register file between several writers: ALU writeback, memory load and debug/loader.
- Runs a power-on/clear sequence that zeroes every register before normal traffic is allowed.
- Runs round-robin arbitration among the writers.
- Presents a one-entry staged write to the register file, plus a busy scoreboard so decode can detect pending writes.

---
 rtl/regfile_write_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Single write port arbiter for the 4x8 register file: zeroes every register after
// reset or on clear, then round-robins ALU / load / debug writers through a one-entry stage.
module regfile_write_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic                        clear_req,
   input  logic                        rf_hold,
   output logic                        rf_wr,
   output logic [ADDR_W-1:0]           rf_ad,
   output logic [DATA_W-1:0]           rf_rd,
   output logic [(2**ADDR_W)-1:0]      busy,
   output logic                        init_done,
   output logic [1:0]                  last_grant
);

   localparam int NUM_REG = 2**ADDR_W;

   // Handshake: requester i transfers at a rising edge when req_valid[i] && req_ready[i];
   // req_ready is a one-hot grant that never depends on whether the granted data is consumed.

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   init_cnt;
   logic                stage_valid;
   logic [ADDR_W-1:0]   stage_addr;
   logic [DATA_W-1:0]   stage_data;

   logic                can_accept;
   logic                commit;
   logic                grant_any;
   logic [1:0]          grant_idx;
   logic [1:0]          cand;

   // Round-robin search starts one past the most recent winner.
   always_comb begin
      grant_any  = 1'b0;
      grant_idx  = last_grant;
      cand       = '0;
      can_accept = !stage_valid || !rf_hold;
      commit     = stage_valid && !rf_hold;
      if (state == ST_RUN && can_accept && !clear_req) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand = 2'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_any && req_valid[cand]) begin
               grant_any = 1'b1;
               grant_idx = cand;
            end
         end
      end
   end

   assign req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;

   // The zeroing write is combinational in INIT, so it is also gated by reset itself.
   always_comb begin
      rf_wr = commit;
      rf_ad = stage_addr;
      rf_rd = stage_data;
      if (state == ST_INIT) begin
         rf_wr = rst_n && !rf_hold;
         rf_ad = init_cnt;
         rf_rd = '0;
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_REG; r++) begin
         busy[r] = stage_valid && (stage_addr == ADDR_W'(r));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_INIT;
         init_cnt    <= '0;
         stage_valid <= 1'b0;
         stage_addr  <= '0;
         stage_data  <= '0;
         last_grant  <= 2'(NUM_REQ-1);
         init_done   <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               if (!rf_hold) begin
                  if (init_cnt == ADDR_W'(NUM_REG-1)) begin
                     state     <= ST_RUN;
                     init_cnt  <= '0;
                     init_done <= 1'b1;
                  end else begin
                     init_cnt <= init_cnt + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (grant_any) begin
                  stage_valid <= 1'b1;
                  stage_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                  stage_data  <= req_data[grant_idx*DATA_W +: DATA_W];
                  last_grant  <= grant_idx;
               end else if (commit) begin
                  stage_valid <= 1'b0;
               end
               // clear_req suppresses grants, so the stage is empty by the time INIT starts.
               if (clear_req && (!stage_valid || commit)) begin
                  state     <= ST_INIT;
                  init_cnt  <= '0;
                  init_done <= 1'b0;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based reference model predicts grants and the
// register-file write stream; a monitor pops expected writes whenever rf_wr is seen.
module tb_regfile_write_arbiter;

   localparam int NUM_REQ = 3;
   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 2;
   localparam int NUM_REG = 4;
   localparam int WR_W    = ADDR_W + DATA_W;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data = '0;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      clear_req = 1'b0;
   logic                      rf_hold = 1'b0;
   logic                      rf_wr;
   logic [ADDR_W-1:0]         rf_ad;
   logic [DATA_W-1:0]         rf_rd;
   logic [NUM_REG-1:0]        busy;
   logic                      init_done;
   logic [1:0]                last_grant;

   int n_tests = 0;
   int n_fail  = 0;

   logic [WR_W-1:0] exp_q[$];
   logic [WR_W-1:0] pend_q[$];
   bit m_init = 1'b1;
   int m_addr = 0;
   int m_last = NUM_REQ - 1;

   regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .clear_req(clear_req), .rf_hold(rf_hold),
      .rf_wr(rf_wr), .rf_ad(rf_ad), .rf_rd(rf_rd), .busy(busy),
      .init_done(init_done), .last_grant(last_grant)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = '0;
      clear_req = 1'b0;
      rf_hold   = 1'b0;
   endtask

   // Reference model: zeroing pass over all addresses, then a list of accepted-but-uncommitted writes.
   always @(negedge clk) begin : model_p
      logic [2:0] exp_ready;
      logic [3:0] exp_busy;
      int         pick;
      bit         full;
      bit         commit;
      if (!rst_n) begin
         m_init = 1'b1;
         m_addr = 0;
         m_last = NUM_REQ - 1;
         pend_q.delete();
         exp_q.delete();
      end else begin
         check("last_grant", 32'(last_grant), 32'(m_last));
         if (m_init) begin
            check("init_done_init", 32'(init_done), 32'd0);
            check("req_ready_init", 32'(req_ready), 32'd0);
            check("busy_init", 32'(busy), 32'd0);
            if (!rf_hold) begin
               exp_q.push_back({2'(m_addr), 8'h00});
               if (m_addr == NUM_REG - 1) begin
                  m_init = 1'b0;
                  m_addr = 0;
               end else begin
                  m_addr++;
               end
            end
         end else begin
            full     = pend_q.size() != 0;
            commit   = full && !rf_hold;
            exp_busy = full ? 4'(1 << pend_q[0][WR_W-1:DATA_W]) : 4'd0;
            pick     = -1;
            if ((!full || !rf_hold) && !clear_req) begin
               for (int k = 1; k <= NUM_REQ; k++) begin
                  int c;
                  c = (m_last + k) % NUM_REQ;
                  if (pick < 0 && req_valid[c]) pick = c;
               end
            end
            exp_ready = (pick >= 0) ? 3'(1 << pick) : 3'd0;
            check("init_done_run", 32'(init_done), 32'd1);
            check("busy", 32'(busy), 32'(exp_busy));
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            if (commit) exp_q.push_back(pend_q.pop_front());
            if (pick >= 0) begin
               pend_q.push_back({req_addr[pick*ADDR_W +: ADDR_W], req_data[pick*DATA_W +: DATA_W]});
               m_last = pick;
            end
            if (clear_req && (!full || commit)) begin
               m_init = 1'b1;
               m_addr = 0;
            end
         end
      end
   end

   // Monitor: every visible write must match the next predicted write, and nothing may be left over.
   always @(negedge clk) begin : monitor_p
      logic [WR_W-1:0] exp_w;
      #1;
      if (rst_n) begin
         if (rf_wr) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got ad=%0d rd=%0h expected no write at %0t", rf_ad, rf_rd, $time);
            end else begin
               exp_w = exp_q.pop_front();
               check("write", 32'({rf_ad, rf_rd}), 32'(exp_w));
            end
         end
         check("missing_write", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   end

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) tick();

      // single ALU write: addr 2, data 13
      req_valid = 3'b001;
      req_addr  = {2'd0, 2'd0, 2'd2};
      req_data  = {8'd0, 8'd0, 8'd13};
      tick();
      req_valid = '0;
      repeat (3) tick();

      // all writers valid, then a 3-cycle hold, then a clear pulse with requester 1 waiting
      req_addr  = {2'd3, 2'd1, 2'd0};
      req_data  = {8'd15, 8'd14, 8'd12};
      req_valid = 3'b111;
      repeat (7) tick();
      rf_hold = 1'b1;
      repeat (3) tick();
      rf_hold = 1'b0;
      repeat (3) tick();
      req_valid = 3'b010;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (10) tick();
      idle();

      repeat (400) begin
         req_valid = 3'($urandom_range(0, 7));
         req_addr  = 6'($urandom);
         req_data  = 24'($urandom);
         rf_hold   = ($urandom_range(0, 3) == 0);
         clear_req = ($urandom_range(0, 40) == 0);
         tick();
      end

      // asynchronous reset in the middle of the zeroing pass (counter = 2)
      idle();
      repeat (6) tick();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (2) tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_rf_wr", 32'(rf_wr), 32'd0);
      check("rst_rf_ad", 32'(rf_ad), 32'd0);
      check("rst_rf_rd", 32'(rf_rd), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_last_grant", 32'(last_grant), 32'd2);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) tick();

      repeat (200) begin
         req_valid = 3'($urandom_range(0, 7));
         req_addr  = 6'($urandom);
         req_data  = 24'($urandom);
         rf_hold   = ($urandom_range(0, 4) == 0);
         clear_req = ($urandom_range(0, 60) == 0);
         tick();
      end
      idle();
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
